// File: rtl/h_u_pg_rca16_acc.sv
// Accumulates N unsigned 17-bit adder sums into a 20-bit total and presents the
// total with a valid/ready handshake. Two states: collecting beats and holding a
// result. No bypass: a result must be taken before the next group can start.
`timescale 1ns/1ps
module h_u_pg_rca16_acc #(
  parameter int unsigned N = 4  // beats per result, 1..8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [16:0] in_sum,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_acc,
  output logic [3:0]  beat_cnt
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  localparam logic [3:0] LastCnt = 4'(N - 1);

  state_e      state_q, state_d;
  logic [19:0] acc_q;
  logic [19:0] out_acc_q;
  logic [3:0]  beat_cnt_q;
  logic        beat;
  logic        last_beat;
  logic        out_hs;
  logic [19:0] acc_sum;

  assign beat      = in_valid & in_ready;
  assign last_beat = (beat_cnt_q == LastCnt);
  assign out_hs    = out_valid & out_ready;
  assign acc_sum   = acc_q + {3'b000, in_sum};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the Nth beat enters HOLD, the output handshake leaves it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (beat && last_beat) state_d = StHold;
      StHold:  if (out_hs)            state_d = StAccum;
    endcase
  end

  // Outputs: in_ready is gated by reset so nothing looks acceptable during reset.
  always_comb begin
    in_ready  = rst_n && (state_q == StAccum) && !clr;
    out_valid = (state_q == StHold);
    out_acc   = out_acc_q;
    beat_cnt  = beat_cnt_q;
  end

  // Datapath: clr only matters while collecting; HOLD contents are never touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      out_acc_q  <= '0;
      beat_cnt_q <= '0;
    end else if (state_q == StAccum) begin
      if (clr) begin
        acc_q      <= '0;
        beat_cnt_q <= '0;
      end else if (beat) begin
        if (last_beat) begin
          out_acc_q  <= acc_sum;
          acc_q      <= '0;
          beat_cnt_q <= '0;
        end else begin
          acc_q      <= acc_sum;
          beat_cnt_q <= beat_cnt_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_h_u_pg_rca16_acc.sv
// Bench for h_u_pg_rca16_acc: a per-cycle vector table for N=4, hand-written
// sequences for N=8 overflow-free maximum and asynchronous reset, and a
// randomized ordered-scoreboard run for N=1.
`timescale 1ns/1ps
module tb_h_u_pg_rca16_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=4 instance
  logic        c4, v4, ir4, ov4, r4;
  logic [16:0] s4;
  logic [19:0] oa4;
  logic [3:0]  bc4;
  // N=8 instance
  logic        c8, v8, ir8, ov8, r8;
  logic [16:0] s8;
  logic [19:0] oa8;
  logic [3:0]  bc8;
  // N=1 instance
  logic        c1, v1, ir1, ov1, r1;
  logic [16:0] s1;
  logic [19:0] oa1;
  logic [3:0]  bc1;

  h_u_pg_rca16_acc #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(c4), .in_valid(v4), .in_sum(s4), .in_ready(ir4),
    .out_valid(ov4), .out_ready(r4), .out_acc(oa4), .beat_cnt(bc4)
  );
  h_u_pg_rca16_acc #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .clr(c8), .in_valid(v8), .in_sum(s8), .in_ready(ir8),
    .out_valid(ov8), .out_ready(r8), .out_acc(oa8), .beat_cnt(bc8)
  );
  h_u_pg_rca16_acc #(.N(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(c1), .in_valid(v1), .in_sum(s1), .in_ready(ir1),
    .out_valid(ov1), .out_ready(r1), .out_acc(oa1), .beat_cnt(bc1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [16:0] s;
    logic        c;
    logic        r;
    logic        ir;
    logic        ov;
    logic [19:0] oa;
    logic [3:0]  bc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [16:0] s, input logic c, input logic r,
                     input logic ir, input logic ov, input logic [19:0] oa,
                     input logic [3:0] bc);
    vec_t t;
    t.v = v; t.s = s; t.c = c; t.r = r; t.ir = ir; t.ov = ov; t.oa = oa; t.bc = bc;
    vecs.push_back(t);
  endtask

  // One N=4 cycle: drive at negedge, check in_ready before the edge and state after.
  task automatic step4(input logic v, input logic [16:0] s, input logic c, input logic r,
                       input logic ir, input logic ov, input logic [19:0] oa,
                       input logic [3:0] bc, input string tag);
    @(negedge clk);
    v4 = v; s4 = s; c4 = c; r4 = r;
    #1;
    chk({tag, ".in_ready"}, 32'(ir4), 32'(ir));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(ov4), 32'(ov));
    chk({tag, ".out_acc"}, 32'(oa4), 32'(oa));
    chk({tag, ".beat_cnt"}, 32'(bc4), 32'(bc));
  endtask

  logic [16:0] exp_q[$];
  int          n_out;

  initial begin
    rst_n = 1'b0;
    {c4, v4, r4, s4} = '0;
    {c8, v8, r8, s8} = '0;
    {c1, v1, r1, s1} = '0;
    #1;
    chk("rst.in_ready", 32'(ir4), 0);
    chk("rst.out_valid", 32'(ov4), 0);
    chk("rst.out_acc", 32'(oa4), 0);
    chk("rst.beat_cnt", 32'(bc4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---- N=4 table ----
    add(1, 1, 0, 0, 1, 0, 0, 1);
    add(1, 2, 0, 0, 1, 0, 0, 2);
    add(1, 3, 0, 0, 1, 0, 0, 3);
    add(1, 4, 0, 0, 1, 1, 10, 0);               // 1+2+3+4
    for (int i = 0; i < 5; i++) add(1, 9, 0, 0, 0, 1, 10, 0);  // backpressure
    add(1, 9, 0, 1, 0, 0, 10, 0);               // handshake, no bypass
    add(1, 5, 0, 0, 1, 0, 10, 1);               // first beat of next group
    add(0, 5, 0, 0, 1, 0, 10, 1);               // stall
    add(1, 5, 1, 0, 0, 0, 10, 0);               // clr discards partial + in_sum
    add(1, 7, 0, 0, 1, 0, 10, 1);
    add(1, 9, 0, 0, 1, 0, 10, 2);
    add(1, 5, 1, 0, 0, 0, 10, 0);               // clr with valid data
    add(1, 1, 0, 0, 1, 0, 10, 1);
    add(1, 1, 0, 0, 1, 0, 10, 2);
    add(1, 1, 0, 0, 1, 0, 10, 3);
    add(1, 1, 0, 0, 1, 1, 4, 0);
    add(1, 5, 1, 0, 0, 1, 4, 0);                // clr ignored in HOLD
    add(0, 0, 0, 1, 0, 0, 4, 0);
    add(1, 3, 0, 0, 1, 0, 4, 1);                // toggling valid
    add(0, 3, 0, 0, 1, 0, 4, 1);
    add(1, 3, 0, 0, 1, 0, 4, 2);
    add(0, 3, 0, 0, 1, 0, 4, 2);
    add(1, 3, 0, 0, 1, 0, 4, 3);
    add(1, 3, 0, 0, 1, 1, 12, 0);
    add(0, 0, 0, 1, 0, 0, 12, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step4(vecs[i].v, vecs[i].s, vecs[i].c, vecs[i].r, vecs[i].ir, vecs[i].ov,
            vecs[i].oa, vecs[i].bc, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    v4 = 1'b0; r4 = 1'b0; c4 = 1'b0;

    // ---- N=8 maximum ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v8 = 1'b1; s8 = 17'h1FFFF;
      @(posedge clk);
      #1;
      if (i == 6) chk("n8.cnt7", 32'(bc8), 7);
    end
    chk("n8.out_valid", 32'(ov8), 1);
    chk("n8.out_acc", 32'(oa8), 32'h000FFFF8);
    chk("n8.beat_cnt", 32'(bc8), 0);
    @(negedge clk);
    v8 = 1'b0; r8 = 1'b1;
    @(posedge clk);
    #1;
    chk("n8.hs", 32'(ov8), 0);
    r8 = 1'b0;

    // ---- reset mid-group ----
    step4(1, 5, 0, 0, 1, 0, 12, 1, "rg.b1");
    step4(1, 6, 0, 0, 1, 0, 12, 2, "rg.b2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rg.out_acc", 32'(oa4), 0);
    chk("rg.beat_cnt", 32'(bc4), 0);
    chk("rg.out_valid", 32'(ov4), 0);
    chk("rg.in_ready", 32'(ir4), 0);
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step4(1, 2, 0, 0, 1, 0, 0, 1, "rg.p1");
    step4(1, 2, 0, 0, 1, 0, 0, 2, "rg.p2");
    step4(1, 2, 0, 0, 1, 0, 0, 3, "rg.p3");
    step4(1, 2, 0, 0, 1, 1, 8, 0, "rg.p4");

    // ---- reset mid-HOLD ----
    step4(0, 0, 0, 0, 0, 1, 8, 0, "rh.hold");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rh.out_valid", 32'(ov4), 0);
    chk("rh.out_acc", 32'(oa4), 0);
    chk("rh.in_ready", 32'(ir4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step4(1, 3, 0, 0, 1, 0, 0, 1, "rh.fresh");
    @(negedge clk);
    v4 = 1'b0;

    // ---- N=1 random ordered scoreboard ----
    n_out = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      v1 = 1'($urandom_range(0, 1));
      s1 = 17'($urandom);
      r1 = 1'($urandom_range(0, 1));
      #1;
      if (v1 && ir1) exp_q.push_back(s1);
      if (ov1 && r1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("n1.dup", 32'(n_out), 0);
        end else begin
          chk("n1.out_acc", 32'(oa1), 32'(exp_q.pop_front()));
        end
      end
      @(posedge clk);
    end
    chk("n1.pending_le1", 32'(exp_q.size() <= 1), 1);
    chk("n1.some_out", 32'(n_out > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
